mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Multicycle data-memory access sequencer between the MIPS datapath (MEM stage) and the shared memory/UART bus.
- Accepts one load/store request at a time and computes byte enables and lane-shifted write data.
- Runs a request/acknowledge handshake with wait states and a timeout, then returns aligned, sign- or zero-extended load data.
- Flags misaligned accesses and bus timeouts to the exception logic.

Parameters:
- TIMEOUT, 16, max cycles to wait for bus_ack before aborting (must be ≥2).
- CNT_W, 5, timeout counter width (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  CPU access request, sampled in IDLE only.
- we  in  1  1=store, 0=load.
- op  in  2  access size: `BE_SW`=2'b00 word, `BE_SH`=2'b01 half, `BE_SB`=2'b10 byte; 2'b11 is illegal.
- ld_unsigned  in  1  1=zero-extend lb/lh (lbu/lhu), 0=sign-extend.
- addr  in  32  byte address (ALUOut).
- wdata  in  32  store data, right-justified.
- busy  out  1  high while a request is in progress (ACCESS state); CPU stalls on it.
- done  out  1  one-cycle pulse on successful completion.
- rdata  out  32  extended load data, valid when done pulses, held until the next done.
- addr_err  out  1  one-cycle pulse: misaligned address or illegal op; no bus cycle is issued.
- bus_timeout  out  1  one-cycle pulse: ack not received within TIMEOUT cycles.
- bus_req  out  1  bus request, held until ack or timeout.
- bus_we  out  1  bus write strobe.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  bus read word.
- bus_ack  in  1  bus completion, sampled while bus_req=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including rdata and the counter.
- States: IDLE, ACCESS, RESP.
- IDLE, req=1:
  - If the access is misaligned (SW with addr[1:0]≠0, SH with addr[0]=1) or op=2'b11: pulse addr_err next cycle, stay in IDLE.
  - Otherwise register we, op, ld_unsigned, addr[1:0], bus_addr, bus_be and bus_wdata; go to ACCESS.
  - bus_req rises 1 cycle after req.
- Byte enables:
  - SW: 1111.
  - SH: addr[1]=1 gives 1100, else 0011.
  - SB: one-hot at bit addr[1:0] (00→0001 … 11→1000).
- bus_wdata:
  - SW: wdata.
  - SH: {2{wdata[15:0]}}.
  - SB: {4{wdata[7:0]}}.
- ACCESS: bus_req=1, busy=1; all bus outputs held stable.
  - Counter increments each cycle.
  - bus_ack=1: go to RESP; capture rdata for loads; clear the counter.
  - If the counter reaches TIMEOUT-1 with no ack: pulse bus_timeout, go to IDLE, drop bus_req.
  - Ack in the same cycle as the timeout limit: the ack wins.
- RESP: done=1 for exactly one cycle; bus_req=0, busy=0; next state IDLE.
  - Minimum latency from req to done is 3 cycles with a zero-wait ack in the first ACCESS cycle.
  - A new req is accepted only in IDLE. req held high through RESP starts a new access on the following IDLE cycle; no request merging.
- Load extraction uses the registered addr[1:0]:
  - Word: bus_rdata.
  - Half: the selected 16 bits, extended per ld_unsigned.
  - Byte: the selected 8 bits, extended per ld_unsigned.
- Stores leave rdata unchanged.
- CPU input changes during ACCESS are ignored because all inputs are registered at acceptance.
- Reset asserted mid-ACCESS: bus_req drops immediately; no done or error pulse.
- bus_ack in IDLE or RESP is ignored.

Decomposition:
- Shared header ctrl_encode_def.v holds:
  - the `BE_SW`/`BE_SH`/`BE_SB` encodings;
  - new state encodings `MAC_IDLE`/`MAC_ACCESS`/`MAC_RESP` (2'b00/01/10).
- Sub-module: the existing byte-enable calculator (becalc) is instantiated for bus_be. Its outputs are gated to 0000 when the op is illegal.
- Load extraction stays inline as a combinational block feeding the rdata register.

Test Plan:
- SW store, addr=0x100, wdata=0xDEADBEEF, ack after 2 wait cycles → bus_addr=0x100, be=1111, wdata=0xDEADBEEF; done 5 cycles after req; busy high for 3 cycles.
- SB store, addr=0x203, wdata=0x000000A5, immediate ack → be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x200, done at cycle 3.
- LB, addr=0x302, bus_rdata=0x12F45678, ld_unsigned=0 → rdata=0xFFFFFFF4; repeat with ld_unsigned=1 → 0x000000F4.
- LH, addr=0x402, bus_rdata=0x8001_7FFF → rdata=0xFFFF8001; then SH to addr=0x401 → addr_err pulse, bus_req never asserts.
- No ack, TIMEOUT=16 → bus_timeout pulse exactly 16 cycles after bus_req rises, no done; next req is accepted normally.
- rst_n low during ACCESS → bus_req, busy and the counter clear asynchronously; after release, a fresh SW completes correctly.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and helpers for the MEM-stage bus access sequencer.
// Access-size codes match the datapath's BE_* control encoding.
package mem_access_ctrl_pkg;

   localparam logic [1:0] BE_SW  = 2'b00;
   localparam logic [1:0] BE_SH  = 2'b01;
   localparam logic [1:0] BE_SB  = 2'b10;
   localparam logic [1:0] BE_ILL = 2'b11;

   typedef enum logic [1:0] {
      MAC_IDLE   = 2'b00,
      MAC_ACCESS = 2'b01,
      MAC_RESP   = 2'b10
   } mac_state_e;

   function automatic logic is_bad_access(input logic [1:0] op, input logic [1:0] lo);
      logic bad;
      bad = (op == BE_ILL) || (op == BE_SW && lo != 2'b00) || (op == BE_SH && lo[0]);
      return bad;
   endfunction

   // Stores are replicated into every lane; byte enables pick the live one.
   function automatic logic [31:0] lane_wdata(input logic [1:0] op, input logic [31:0] d);
      logic [31:0] res;
      case (op)
         BE_SH:   res = {2{d[15:0]}};
         BE_SB:   res = {4{d[7:0]}};
         default: res = d;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_becalc.sv
// Byte-enable calculator: maps access size and low address bits to lane strobes.
module mem_access_ctrl_becalc
   import mem_access_ctrl_pkg::*;
(
   input  logic [1:0] i_op,
   input  logic [1:0] i_addr_lo,
   output logic [3:0] o_be
);

   always_comb begin
      o_be = 4'b0000;
      case (i_op)
         BE_SW:   o_be = 4'b1111;
         BE_SH:   o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
         BE_SB:   o_be = 4'b0001 << i_addr_lo;
         default: o_be = 4'b0000;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer between the MEM stage and the shared bus:
// req/ack handshake with timeout, lane steering and load extension.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  op,
   input  logic        ld_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        addr_err,
   output logic        bus_timeout,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   mac_state_e       r_state, w_next;
   logic             r_we, r_uns;
   logic [1:0]       r_op, r_lo;
   logic [31:0]      r_bus_addr, r_bus_wdata, r_rdata;
   logic [3:0]       r_bus_be;
   logic [CNT_W-1:0] r_cnt;
   logic             r_addr_err, r_timeout;

   logic             w_accept, w_bad, w_ack, w_expire;
   logic [3:0]       w_be_raw, w_be;
   logic [15:0]      w_shift;
   logic [31:0]      w_ld_data;

   mem_access_ctrl_becalc u_becalc (
      .i_op      (op),
      .i_addr_lo (addr[1:0]),
      .o_be      (w_be_raw)
   );

   assign w_be = (op == BE_ILL) ? 4'b0000 : w_be_raw;

   // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= MAC_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_bad    = 1'b0;
      w_ack    = 1'b0;
      w_expire = 1'b0;
      case (r_state)
         MAC_IDLE: begin
            if (req) begin
               if (is_bad_access(op, addr[1:0])) begin
                  w_bad = 1'b1;
               end else begin
                  w_accept = 1'b1;
                  w_next   = MAC_ACCESS;
               end
            end
         end
         MAC_ACCESS: begin
            // An ack on the final allowed cycle still completes the access.
            if (bus_ack) begin
               w_ack  = 1'b1;
               w_next = MAC_RESP;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_expire = 1'b1;
               w_next   = MAC_IDLE;
            end
         end
         MAC_RESP: w_next = MAC_IDLE;
         default:  w_next = MAC_IDLE;
      endcase
   end

   assign w_shift = 16'(bus_rdata >> {r_lo, 3'b000});

   always_comb begin
      w_ld_data = bus_rdata;
      case (r_op)
         BE_SH:   w_ld_data = {{16{~r_uns & w_shift[15]}}, w_shift[15:0]};
         BE_SB:   w_ld_data = {{24{~r_uns & w_shift[7]}},  w_shift[7:0]};
         default: w_ld_data = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == MAC_ACCESS && !w_ack && !w_expire) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we        <= 1'b0;
         r_uns       <= 1'b0;
         r_op        <= BE_SW;
         r_lo        <= 2'b00;
         r_bus_addr  <= '0;
         r_bus_be    <= '0;
         r_bus_wdata <= '0;
         r_rdata     <= '0;
         r_addr_err  <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_addr_err <= w_bad;
         r_timeout  <= w_expire;
         if (w_accept) begin
            r_we        <= we;
            r_uns       <= ld_unsigned;
            r_op        <= op;
            r_lo        <= addr[1:0];
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= lane_wdata(op, wdata);
         end
         if (w_ack && !r_we) r_rdata <= w_ld_data;
      end
   end

   assign busy        = (r_state == MAC_ACCESS);
   assign bus_req     = (r_state == MAC_ACCESS);
   assign bus_we      = (r_state == MAC_ACCESS) & r_we;
   assign done        = (r_state == MAC_RESP);
   assign rdata       = r_rdata;
   assign addr_err    = r_addr_err;
   assign bus_timeout = r_timeout;
   assign bus_addr    = r_bus_addr;
   assign bus_be      = r_bus_be;
   assign bus_wdata   = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stores, loads, errors, timeout, back-to-back and reset.
module tb_mem_access_ctrl;

   localparam logic [1:0] OP_W = 2'b00;
   localparam logic [1:0] OP_H = 2'b01;
   localparam logic [1:0] OP_B = 2'b10;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req = 1'b0, we = 1'b0, ld_unsigned = 1'b0, bus_ack = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
   logic        busy, done, addr_err, bus_timeout, bus_req, bus_we;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   int n_checks = 0;
   int n_errors = 0;

   mem_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .op(op),
      .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .addr_err(addr_err),
      .bus_timeout(bus_timeout), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [1:0] o, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
      we = w; op = o; ld_unsigned = u; addr = a; wdata = d; req = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({busy, done, addr_err, bus_timeout, bus_req, bus_we} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, addr_err, bus_timeout, bus_req, bus_we});
      end
      n_checks++;
      if ({rdata, bus_addr, bus_wdata, bus_be} !== 100'b0) begin
         n_errors++;
         $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%b expected all zero", rdata, bus_addr, bus_wdata, bus_be);
      end
      n_checks++;
      if (dut.r_cnt !== 5'd0) begin
         n_errors++;
         $display("FAIL reset_cnt: got %0d expected 0", dut.r_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_sw_wait();
      drive(1'b1, OP_W, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
      tick();
      req = 1'b0; addr = 32'hFFFF_FFFC; wdata = 32'h0; op = OP_B;
      n_checks++;
      if ({bus_req, busy, done, bus_we} !== 4'b1101) begin
         n_errors++;
         $display("FAIL sw_start: req/busy/done/we got %b expected 1101", {bus_req, busy, done, bus_we});
      end
      n_checks++;
      if ({bus_addr, bus_be, bus_wdata} !== {32'h0000_0100, 4'b1111, 32'hDEAD_BEEF}) begin
         n_errors++;
         $display("FAIL sw_bus: addr=%h be=%b wdata=%h expected 00000100 1111 deadbeef", bus_addr, bus_be, bus_wdata);
      end
      tick();
      n_checks++;
      if ({bus_req, busy, done, bus_addr} !== {3'b110, 32'h0000_0100}) begin
         n_errors++;
         $display("FAIL sw_wait1: req/busy/done got %b addr=%h expected 110 00000100", {bus_req, busy, done}, bus_addr);
      end
      tick();
      n_checks++;
      if ({bus_req, busy, done, bus_wdata} !== {3'b110, 32'hDEAD_BEEF}) begin
         n_errors++;
         $display("FAIL sw_wait2: req/busy/done got %b wdata=%h expected 110 deadbeef", {bus_req, busy, done}, bus_wdata);
      end
      bus_ack = 1'b1;
      tick();
      n_checks++;
      if ({bus_req, busy, done, rdata} !== {3'b001, 32'h0}) begin
         n_errors++;
         $display("FAIL sw_done: req/busy/done got %b rdata=%h expected 001 00000000", {bus_req, busy, done}, rdata);
      end
      tick();
      n_checks++;
      if ({bus_req, busy, done} !== 3'b000) begin
         n_errors++;
         $display("FAIL sw_idle_ack_ignored: got %b expected 000", {bus_req, busy, done});
      end
      bus_ack = 1'b0;
   endtask

   task automatic test_sb_store();
      drive(1'b1, OP_B, 1'b0, 32'h0000_0203, 32'h0000_00A5);
      tick();
      req = 1'b0;
      n_checks++;
      if ({bus_addr, bus_be, bus_wdata} !== {32'h0000_0200, 4'b1000, 32'hA5A5_A5A5}) begin
         n_errors++;
         $display("FAIL sb_bus: addr=%h be=%b wdata=%h expected 00000200 1000 a5a5a5a5", bus_addr, bus_be, bus_wdata);
      end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      n_checks++;
      if ({done, busy} !== 2'b10) begin
         n_errors++;
         $display("FAIL sb_done: done/busy got %b expected 10", {done, busy});
      end
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         n_errors++;
         $display("FAIL sb_done_pulse: got %b expected 0", done);
      end
   endtask

   task automatic test_lb();
      logic [31:0] exp_r [2];
      exp_r[0] = 32'hFFFF_FFF4;
      exp_r[1] = 32'h0000_00F4;
      for (int u = 0; u < 2; u++) begin
         bus_rdata = 32'h12F4_5678;
         drive(1'b0, OP_B, 1'(u), 32'h0000_0302, 32'h0);
         tick();
         req = 1'b0;
         bus_ack = 1'b1;
         n_checks++;
         if ({bus_we, bus_be} !== 5'b0_0100) begin
            n_errors++;
            $display("FAIL lb_bus[%0d]: we=%b be=%b expected 0 0100", u, bus_we, bus_be);
         end
         tick();
         bus_ack = 1'b0;
         bus_rdata = 32'h0;
         n_checks++;
         if ({done, rdata} !== {1'b1, exp_r[u]}) begin
            n_errors++;
            $display("FAIL lb_data[%0d]: done=%b rdata=%h expected 1 %h", u, done, rdata, exp_r[u]);
         end
         tick();
         n_checks++;
         if (rdata !== exp_r[u]) begin
            n_errors++;
            $display("FAIL lb_hold[%0d]: rdata=%h expected %h", u, rdata, exp_r[u]);
         end
      end
   endtask

   task automatic test_lh_and_errors();
      bus_rdata = 32'h8001_7FFF;
      drive(1'b0, OP_H, 1'b0, 32'h0000_0402, 32'h0);
      tick();
      req = 1'b0;
      bus_ack = 1'b1;
      n_checks++;
      if (bus_be !== 4'b1100) begin
         n_errors++;
         $display("FAIL lh_be: got %b expected 1100", bus_be);
      end
      tick();
      bus_ack = 1'b0;
      n_checks++;
      if ({done, rdata} !== {1'b1, 32'hFFFF_8001}) begin
         n_errors++;
         $display("FAIL lh_data: done=%b rdata=%h expected 1 ffff8001", done, rdata);
      end
      tick();
      // misaligned half, misaligned word, illegal op
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       drive(1'b1, OP_H,  1'b0, 32'h0000_0401, 32'h1234);
            1:       drive(1'b1, OP_W,  1'b0, 32'h0000_0102, 32'h1234);
            default: drive(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
         endcase
         tick();
         req = 1'b0;
         n_checks++;
         if ({addr_err, bus_req, busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL err_pulse[%0d]: err/req/busy got %b expected 100", k, {addr_err, bus_req, busy});
         end
         tick();
         n_checks++;
         if ({addr_err, bus_req, rdata} !== {2'b00, 32'hFFFF_8001}) begin
            n_errors++;
            $display("FAIL err_after[%0d]: err/req got %b rdata=%h expected 00 ffff8001", k, {addr_err, bus_req}, rdata);
         end
      end
   endtask

   task automatic test_timeout();
      drive(1'b0, OP_W, 1'b0, 32'h0000_0500, 32'h0);
      tick();
      req = 1'b0;
      for (int k = 1; k < 16; k++) begin
         tick();
         n_checks++;
         if ({bus_timeout, bus_req} !== 2'b01) begin
            n_errors++;
            $display("FAIL to_wait[%0d]: timeout/req got %b expected 01", k, {bus_timeout, bus_req});
         end
      end
      tick();
      n_checks++;
      if ({bus_timeout, bus_req, busy, done} !== 4'b1000) begin
         n_errors++;
         $display("FAIL to_pulse: timeout/req/busy/done got %b expected 1000", {bus_timeout, bus_req, busy, done});
      end
      bus_rdata = 32'hCAFE_F00D;
      drive(1'b0, OP_W, 1'b0, 32'h0000_0504, 32'h0);
      tick();
      req = 1'b0;
      bus_ack = 1'b1;
      n_checks++;
      if ({bus_timeout, bus_req, bus_addr} !== {2'b01, 32'h0000_0504}) begin
         n_errors++;
         $display("FAIL to_next_start: timeout/req got %b addr=%h expected 01 00000504", {bus_timeout, bus_req}, bus_addr);
      end
      tick();
      bus_ack = 1'b0;
      n_checks++;
      if ({done, rdata} !== {1'b1, 32'hCAFE_F00D}) begin
         n_errors++;
         $display("FAIL to_next_done: done=%b rdata=%h expected 1 cafef00d", done, rdata);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, OP_B, 1'b0, 32'h0000_0010, 32'h0000_003C);
      tick();
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      addr = 32'h0000_0011; wdata = 32'h0000_005A;
      n_checks++;
      if ({done, bus_req} !== 2'b10) begin
         n_errors++;
         $display("FAIL b2b_resp: done/req got %b expected 10", {done, bus_req});
      end
      tick();
      n_checks++;
      if ({done, bus_req} !== 2'b00) begin
         n_errors++;
         $display("FAIL b2b_idle: done/req got %b expected 00", {done, bus_req});
      end
      tick();
      req = 1'b0;
      n_checks++;
      if ({bus_req, bus_be, bus_wdata} !== {1'b1, 4'b0010, 32'h5A5A_5A5A}) begin
         n_errors++;
         $display("FAIL b2b_second: req=%b be=%b wdata=%h expected 1 0010 5a5a5a5a", bus_req, bus_be, bus_wdata);
      end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      n_checks++;
      if (done !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_done: got %b expected 1", done);
      end
      tick();
   endtask

   task automatic test_reset_mid_access();
      drive(1'b1, OP_W, 1'b0, 32'h0000_0700, 32'h1122_3344);
      tick();
      req = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus_req, busy, done, bus_be} !== 7'b0 || dut.r_cnt !== 5'd0) begin
         n_errors++;
         $display("FAIL rst_mid: req/busy/done got %b be=%b cnt=%0d expected 000 0000 0", {bus_req, busy, done}, bus_be, dut.r_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      n_checks++;
      if ({done, addr_err, bus_timeout, bus_req} !== 4'b0) begin
         n_errors++;
         $display("FAIL rst_quiet: done/err/timeout/req got %b expected 0000", {done, addr_err, bus_timeout, bus_req});
      end
      drive(1'b1, OP_W, 1'b0, 32'h0000_0600, 32'h1234_5678);
      tick();
      req = 1'b0;
      bus_ack = 1'b1;
      n_checks++;
      if ({bus_req, bus_addr, bus_be, bus_wdata} !== {1'b1, 32'h0000_0600, 4'b1111, 32'h1234_5678}) begin
         n_errors++;
         $display("FAIL rst_fresh_bus: req=%b addr=%h be=%b wdata=%h expected 1 00000600 1111 12345678", bus_req, bus_addr, bus_be, bus_wdata);
      end
      tick();
      bus_ack = 1'b0;
      n_checks++;
      if ({done, busy} !== 2'b10) begin
         n_errors++;
         $display("FAIL rst_fresh_done: done/busy got %b expected 10", {done, busy});
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sw_wait();
      test_sb_store();
      test_lb();
      test_lh_and_errors();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
